// File: rtl/data_memory_pkg.sv
// Shared encodings for the MEM-stage data memory: access sizes, sweep FSM states
// and the zero word written by the clear sweep.
package data_memory_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10
  } size_e;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  localparam int unsigned WORD_W = 32;
  localparam logic [WORD_W-1:0] CLEAR_WORD = '0;

endpackage

// File: rtl/data_memory_lane_align.sv
// Combinational lane handling: store byte enables and data replication,
// load lane select with sign/zero extension, and the alignment check.
module data_memory_lane_align
  import data_memory_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        unsigned_ld,
  input  logic [1:0]  offset,
  input  logic [31:0] wr_data,
  input  logic [31:0] rd_word,
  output logic [3:0]  byte_en,
  output logic [31:0] wr_word,
  output logic [31:0] rd_data,
  output logic        misaligned
);

  logic [31:0] shifted;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  assign shifted  = rd_word >> {offset, 3'b000};
  assign sel_byte = shifted[7:0];
  assign sel_half = offset[1] ? rd_word[31:16] : rd_word[15:0];

  // Encoding 2'b11 falls through to the word case
  always_comb begin
    byte_en    = 4'b0000;
    wr_word    = '0;
    rd_data    = '0;
    misaligned = 1'b0;
    case (size)
      SIZE_BYTE: begin
        byte_en = 4'b0001 << offset;
        wr_word = {4{wr_data[7:0]}};
        rd_data = unsigned_ld ? {24'd0, sel_byte} : {{24{sel_byte[7]}}, sel_byte};
      end
      SIZE_HALF: begin
        misaligned = offset[0];
        byte_en    = offset[1] ? 4'b1100 : 4'b0011;
        wr_word    = {2{wr_data[15:0]}};
        rd_data    = unsigned_ld ? {16'd0, sel_half} : {{16{sel_half[15]}}, sel_half};
      end
      default: begin
        misaligned = |offset;
        byte_en    = 4'b1111;
        wr_word    = wr_data;
        rd_data    = rd_word;
      end
    endcase
  end

endmodule

// File: rtl/data_memory_sized.sv
// MIPS MEM-stage data memory with sized access and a one-word-per-cycle clear sweep.
// Define DATA_MEMORY_DEBUG_BUS_EN to export the array image on o_bus_debug.
module data_memory_sized
  import data_memory_pkg::*;
#(
  parameter int ADDR_SIZE = 5,
  parameter int DATA_SIZE = 32
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_flush,
  input  logic                   i_req,
  input  logic                   i_wr,
  input  logic [1:0]             i_size,
  input  logic                   i_unsigned,
  input  logic [ADDR_SIZE+1:0]   i_addr,
  input  logic [DATA_SIZE-1:0]   i_data,
  output logic [DATA_SIZE-1:0]   o_data,
  output logic                   o_valid,
  output logic                   o_misaligned,
  output logic                   o_busy
`ifdef DATA_MEMORY_DEBUG_BUS_EN
  ,
  output logic [(2**ADDR_SIZE)*DATA_SIZE-1:0] o_bus_debug
`endif
);

  localparam int DEPTH = 2**ADDR_SIZE;
  localparam logic [ADDR_SIZE-1:0] LAST_IDX = '1;

  if (DATA_SIZE != 32) begin : g_bad_width
    $error("data_memory_sized: DATA_SIZE must be 32");
  end

  state_e                 state;
  logic [ADDR_SIZE-1:0]   counter;
  logic [DATA_SIZE-1:0]   mem [DEPTH];

  logic [ADDR_SIZE-1:0]   word_idx;
  logic [31:0]            rd_word;
  logic [31:0]            rd_data;
  logic [31:0]            wr_word;
  logic [3:0]             byte_en;
  logic                   misaligned;
  logic                   accept;
  logic                   clear_we;
  logic                   store_we;

  assign word_idx = i_addr[ADDR_SIZE+1:2];
  assign rd_word  = mem[word_idx];

  data_memory_lane_align u_lane_align (
    .size        (i_size),
    .unsigned_ld (i_unsigned),
    .offset      (i_addr[1:0]),
    .wr_data     (i_data),
    .rd_word     (rd_word),
    .byte_en     (byte_en),
    .wr_word     (wr_word),
    .rd_data     (rd_data),
    .misaligned  (misaligned)
  );

  // A flush in IDLE wins over a same-cycle request
  assign accept   = (state == ST_IDLE) && !i_flush && i_req;
  assign clear_we = (state == ST_CLEAR);
  assign store_we = accept && i_wr && !misaligned;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state        <= ST_CLEAR;
      counter      <= '0;
      o_data       <= '0;
      o_valid      <= 1'b0;
      o_misaligned <= 1'b0;
      o_busy       <= 1'b1;
    end else begin
      o_valid      <= 1'b0;
      o_misaligned <= 1'b0;
      case (state)
        ST_CLEAR: begin
          if (i_flush) begin
            counter <= '0;
          end else if (counter == LAST_IDX) begin
            counter <= '0;
            state   <= ST_IDLE;
            o_busy  <= 1'b0;
          end else begin
            counter <= counter + ADDR_SIZE'(1);
          end
        end
        default: begin
          if (i_flush) begin
            state   <= ST_CLEAR;
            counter <= '0;
            o_busy  <= 1'b1;
          end else if (accept) begin
            if (misaligned) begin
              o_misaligned <= 1'b1;
            end else begin
              o_valid <= 1'b1;
              if (!i_wr) o_data <= rd_data;
            end
          end
        end
      endcase
    end
  end

  // Array has no reset so it can map to block RAM; zeroing comes from the sweep
  always_ff @(posedge i_clk) begin
    if (clear_we) begin
      mem[counter] <= CLEAR_WORD;
    end else if (store_we) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[word_idx][8*b +: 8] <= wr_word[8*b +: 8];
      end
    end
  end

`ifdef DATA_MEMORY_DEBUG_BUS_EN
  for (genvar j = 0; j < DEPTH; j++) begin : g_debug
    assign o_bus_debug[j*DATA_SIZE +: DATA_SIZE] = mem[j];
  end
`endif

endmodule

// File: tb/tb_data_memory_sized.sv
// Scoreboard bench for data_memory_sized: each request pushes its expected
// response, which is popped and compared one cycle later.
module tb_data_memory_sized;

  localparam int ADDR_SIZE = 5;
  localparam int DEPTH = 2**ADDR_SIZE;

  logic                 i_clk = 1'b0;
  logic                 i_reset = 1'b0;
  logic                 i_flush = 1'b0;
  logic                 i_req = 1'b0;
  logic                 i_wr = 1'b0;
  logic [1:0]           i_size = 2'b10;
  logic                 i_unsigned = 1'b0;
  logic [ADDR_SIZE+1:0] i_addr = '0;
  logic [31:0]          i_data = '0;
  logic [31:0]          o_data;
  logic                 o_valid;
  logic                 o_misaligned;
  logic                 o_busy;
`ifdef DATA_MEMORY_DEBUG_BUS_EN
  logic [DEPTH*32-1:0]  o_bus_debug;
`endif

  data_memory_sized #(.ADDR_SIZE(ADDR_SIZE), .DATA_SIZE(32)) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_flush      (i_flush),
    .i_req        (i_req),
    .i_wr         (i_wr),
    .i_size       (i_size),
    .i_unsigned   (i_unsigned),
    .i_addr       (i_addr),
    .i_data       (i_data),
    .o_data       (o_data),
    .o_valid      (o_valid),
    .o_misaligned (o_misaligned),
    .o_busy       (o_busy)
`ifdef DATA_MEMORY_DEBUG_BUS_EN
    ,
    .o_bus_debug  (o_bus_debug)
`endif
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        valid;
    logic        mis;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model_mem [DEPTH];
  logic [31:0] last_data = '0;
  bit          sweeping = 1'b1;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  function automatic bit model_misaligned(input logic [1:0] size, input logic [6:0] addr);
    if (size == 2'b00) return 1'b0;
    if (size == 2'b01) return addr[0];
    return addr[1:0] != 2'b00;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] size, input bit uns, input logic [6:0] addr);
    logic [31:0] w;
    logic [7:0]  b;
    logic [15:0] h;
    w = model_mem[addr[6:2]];
    case (addr[1:0])
      2'd0: b = w[7:0];
      2'd1: b = w[15:8];
      2'd2: b = w[23:16];
      default: b = w[31:24];
    endcase
    h = addr[1] ? w[31:16] : w[15:0];
    if (size == 2'b00) return uns ? {24'd0, b} : {{24{b[7]}}, b};
    if (size == 2'b01) return uns ? {16'd0, h} : {{16{h[15]}}, h};
    return w;
  endfunction

  task automatic model_store(input logic [1:0] size, input logic [6:0] addr, input logic [31:0] data);
    int idx;
    idx = int'(addr[6:2]);
    if (size == 2'b00) begin
      model_mem[idx][8*addr[1:0] +: 8] = data[7:0];
    end else if (size == 2'b01) begin
      model_mem[idx][16*addr[1] +: 16] = data[15:0];
    end else begin
      model_mem[idx] = data;
    end
  endtask

  task automatic applyStimulus(input string tag, input bit flush, input bit wr, input logic [1:0] size,
                               input bit uns, input logic [6:0] addr, input logic [31:0] data);
    exp_t e;
    exp_t got;
    i_flush    = flush;
    i_req      = 1'b1;
    i_wr       = wr;
    i_size     = size;
    i_unsigned = uns;
    i_addr     = addr;
    i_data     = data;
    if (sweeping || flush) begin
      e = '{1'b0, 1'b0, last_data};
    end else if (model_misaligned(size, addr)) begin
      e = '{1'b0, 1'b1, last_data};
    end else if (wr) begin
      model_store(size, addr, data);
      e = '{1'b1, 1'b0, last_data};
    end else begin
      last_data = model_load(size, uns, addr);
      e = '{1'b1, 1'b0, last_data};
    end
    if (flush) begin
      for (int k = 0; k < DEPTH; k++) model_mem[k] = '0;
      sweeping = 1'b1;
    end
    sb.push_back(e);
    @(posedge i_clk);
    #1;
    i_req   = 1'b0;
    i_flush = 1'b0;
    got = sb.pop_front();
    checkOutput({tag, "_valid"}, 32'(o_valid), 32'(got.valid));
    checkOutput({tag, "_mis"}, 32'(o_misaligned), 32'(got.mis));
    checkOutput({tag, "_data"}, o_data, got.data);
  endtask

  task automatic wait_sweep(input string tag, input bit poke);
    int edges;
    bit done;
    edges = 0;
    done  = 1'b0;
    while (!done && edges < 100) begin
      if (poke && edges == 5) begin
        applyStimulus({tag, "_req_busy"}, 1'b0, 1'b0, 2'b10, 1'b0, 7'h10, 32'h0);
      end else begin
        @(posedge i_clk);
        #1;
      end
      edges++;
      if (!o_busy) done = 1'b1;
    end
    checkOutput({tag, "_busy_edges"}, 32'(edges), 32'(DEPTH));
    sweeping = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < DEPTH; k++) model_mem[k] = '0;
    repeat (3) @(posedge i_clk);
    #1;
    checkOutput("rst_busy", 32'(o_busy), 32'd1);
    checkOutput("rst_valid", 32'(o_valid), 32'd0);
    checkOutput("rst_mis", 32'(o_misaligned), 32'd0);
    checkOutput("rst_data", o_data, 32'd0);
    i_reset = 1'b1;
    wait_sweep("init", 1'b0);

`ifdef DATA_MEMORY_DEBUG_BUS_EN
    checkOutput("dbg_zero", 32'(|o_bus_debug), 32'd0);
`endif
    applyStimulus("ld0", 1'b0, 1'b0, 2'b10, 1'b0, 7'h00, 32'h0);

    applyStimulus("st_w", 1'b0, 1'b1, 2'b10, 1'b0, 7'h10, 32'h8899AABB);
    applyStimulus("lb_s13", 1'b0, 1'b0, 2'b00, 1'b0, 7'h13, 32'h0);
    checkOutput("lb_s13_const", o_data, 32'hFFFFFF88);
    applyStimulus("lbu_10", 1'b0, 1'b0, 2'b00, 1'b1, 7'h10, 32'h0);
    checkOutput("lbu_10_const", o_data, 32'h000000BB);

    applyStimulus("st_h", 1'b0, 1'b1, 2'b01, 1'b0, 7'h12, 32'hFFFF7F01);
    applyStimulus("lw_10", 1'b0, 1'b0, 2'b10, 1'b0, 7'h10, 32'h0);
    checkOutput("lw_10_const", o_data, 32'h7F01AABB);
    applyStimulus("lh_s12", 1'b0, 1'b0, 2'b01, 1'b0, 7'h12, 32'h0);
    checkOutput("lh_s12_const", o_data, 32'h00007F01);
`ifdef DATA_MEMORY_DEBUG_BUS_EN
    checkOutput("dbg_w4", o_bus_debug[4*32 +: 32], model_mem[4]);
`endif

    applyStimulus("st_mis", 1'b0, 1'b1, 2'b10, 1'b0, 7'h05, 32'hDEADBEEF);
    applyStimulus("lh_mis", 1'b0, 1'b0, 2'b01, 1'b0, 7'h03, 32'h0);
    applyStimulus("lw_04", 1'b0, 1'b0, 2'b10, 1'b0, 7'h04, 32'h0);
    applyStimulus("st_b", 1'b0, 1'b1, 2'b00, 1'b0, 7'h7D, 32'h000000C3);
    applyStimulus("lhu_7c", 1'b0, 1'b0, 2'b01, 1'b1, 7'h7C, 32'h0);
    applyStimulus("lw_7c", 1'b0, 1'b0, 2'b11, 1'b1, 7'h7C, 32'h0);
    applyStimulus("lw_10b", 1'b0, 1'b0, 2'b10, 1'b0, 7'h10, 32'h0);

    applyStimulus("flush_st", 1'b1, 1'b1, 2'b10, 1'b0, 7'h10, 32'h12345678);
    wait_sweep("flush", 1'b1);
    applyStimulus("lw_after_flush", 1'b0, 1'b0, 2'b10, 1'b0, 7'h10, 32'h0);
    applyStimulus("lw_7c_flush", 1'b0, 1'b0, 2'b10, 1'b0, 7'h7C, 32'h0);

    applyStimulus("st_08", 1'b0, 1'b1, 2'b10, 1'b0, 7'h08, 32'h12345678);
    applyStimulus("lw_08", 1'b0, 1'b0, 2'b10, 1'b0, 7'h08, 32'h0);
    applyStimulus("flush2", 1'b1, 1'b0, 2'b10, 1'b0, 7'h00, 32'h0);
    repeat (10) @(posedge i_clk);
    #2;
    i_reset = 1'b0;
    #1;
    last_data = '0;
    checkOutput("mid_rst_busy", 32'(o_busy), 32'd1);
    checkOutput("mid_rst_valid", 32'(o_valid), 32'd0);
    checkOutput("mid_rst_mis", 32'(o_misaligned), 32'd0);
    checkOutput("mid_rst_data", o_data, 32'd0);
    @(posedge i_clk);
    #1;
    i_reset = 1'b1;
    wait_sweep("rst_sweep", 1'b0);
    applyStimulus("lw_08_rst", 1'b0, 1'b0, 2'b10, 1'b0, 7'h08, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
